// File: rtl/dcache_ecc_scrubber.sv
// dcache_ecc_scrubber: background patrol scrubber for the ECC-protected L1
// dcache arrays. It walks every (set, way) entry through a spare arbiter
// port and reads it. Correctable errors are written back with the decoder's
// corrected line image. Uncorrectable errors are counted and the first one
// is logged. Scrubbing keeps single-bit upsets from building up into
// uncorrectable double-bit errors.
module dcache_ecc_scrubber #(
    parameter int NUM_WORDS  = 256,
    parameter int SET_ASSOC  = 8,
    parameter int LINE_WIDTH = 256,
    parameter int IVL_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = $clog2(NUM_WORDS),
    localparam int WAY_W     = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [IVL_WIDTH-1:0]  interval_i,
    output logic                  req_o,
    output logic                  we_o,
    output logic [IDX_W-1:0]      addr_o,
    output logic [SET_ASSOC-1:0]  way_o,
    output logic [LINE_WIDTH-1:0] wdata_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic                  corr_err_i,
    input  logic                  uncorr_err_i,
    input  logic [LINE_WIDTH-1:0] corr_data_i,
    output logic                  busy_o,
    output logic                  sweep_done_o,
    output logic                  uncorr_o,
    output logic [CNT_WIDTH-1:0]  corr_cnt_o,
    output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
    output logic                  err_vld_o,
    output logic [IDX_W-1:0]      err_addr_o,
    output logic [WAY_W-1:0]      err_way_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_RSP = 3'd3,
        ST_WR_REQ = 3'd4,
        ST_NEXT   = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(SET_ASSOC - 1);

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [WAY_W-1:0]     way_r;
    logic [IVL_WIDTH-1:0] timer_r;

    logic rsp_uncorr_s;
    logic rsp_corr_s;
    logic last_entry_s;

    // Binary way number to the one-hot way select used by the array port.
    function automatic logic [SET_ASSOC-1:0] way_onehot(input logic [WAY_W-1:0] w);
        logic [SET_ASSOC-1:0] oh;
        oh = {SET_ASSOC{1'b0}};
        for (int i = 0; i < SET_ASSOC; i++) begin
            oh[i] = (w == WAY_W'(i));
        end
        return oh;
    endfunction

    // Saturating increment: an all-ones counter stays put instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1'b1);
    endfunction

    // Decode the ECC status of the read response and detect the last entry of a pass.
    always_comb begin
        rsp_uncorr_s = 1'b0;
        rsp_corr_s   = 1'b0;
        if (state_r == ST_RD_RSP && rvalid_i) begin
            rsp_uncorr_s = uncorr_err_i;
            rsp_corr_s   = corr_err_i && !uncorr_err_i;
        end else begin
            rsp_uncorr_s = 1'b0;
            rsp_corr_s   = 1'b0;
        end
        last_entry_s = (idx_r == IDX_LAST) && (way_r == WAY_LAST);
    end

    // Scrub sequencer: cursor, interval timer and all registered port outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            way_r        <= {WAY_W{1'b0}};
            timer_r      <= {IVL_WIDTH{1'b0}};
            req_o        <= 1'b0;
            we_o         <= 1'b0;
            addr_o       <= {IDX_W{1'b0}};
            way_o        <= {SET_ASSOC{1'b0}};
            wdata_o      <= {LINE_WIDTH{1'b0}};
            busy_o       <= 1'b0;
            sweep_done_o <= 1'b0;
            uncorr_o     <= 1'b0;
        end else begin
            sweep_done_o <= 1'b0;
            uncorr_o     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (enable_i) begin
                        timer_r <= interval_i;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable_i) begin
                        state_r <= ST_IDLE;
                    end else if (timer_r == {IVL_WIDTH{1'b0}} || start_i) begin
                        state_r <= ST_RD_REQ;
                        req_o   <= 1'b1;
                        we_o    <= 1'b0;
                        addr_o  <= idx_r;
                        way_o   <= way_onehot(way_r);
                        busy_o  <= 1'b1;
                    end else begin
                        timer_r <= timer_r - IVL_WIDTH'(1'b1);
                    end
                end
                ST_RD_REQ: begin
                    // A pending (ungranted) read is the only request that may be withdrawn.
                    if (gnt_i) begin
                        req_o   <= 1'b0;
                        state_r <= ST_RD_RSP;
                    end else if (!enable_i) begin
                        req_o   <= 1'b0;
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_RSP: begin
                    if (rvalid_i) begin
                        if (uncorr_err_i) begin
                            uncorr_o     <= 1'b1;
                            sweep_done_o <= last_entry_s;
                            state_r      <= ST_NEXT;
                        end else if (corr_err_i) begin
                            wdata_o <= corr_data_i;
                            req_o   <= 1'b1;
                            we_o    <= 1'b1;
                            state_r <= ST_WR_REQ;
                        end else begin
                            sweep_done_o <= last_entry_s;
                            state_r      <= ST_NEXT;
                        end
                    end
                end
                ST_WR_REQ: begin
                    // Write-back always completes once the read was granted.
                    if (gnt_i) begin
                        req_o        <= 1'b0;
                        we_o         <= 1'b0;
                        sweep_done_o <= last_entry_s;
                        state_r      <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (way_r == WAY_LAST) begin
                        way_r <= {WAY_W{1'b0}};
                        idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
                    end else begin
                        way_r <= way_r + WAY_W'(1'b1);
                    end
                    busy_o <= 1'b0;
                    if (enable_i) begin
                        timer_r <= interval_i;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    req_o   <= 1'b0;
                    we_o    <= 1'b0;
                    busy_o  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Error statistics and first-uncorrectable log; clear wins over a same-cycle event.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            corr_cnt_o   <= {CNT_WIDTH{1'b0}};
            uncorr_cnt_o <= {CNT_WIDTH{1'b0}};
            err_vld_o    <= 1'b0;
            err_addr_o   <= {IDX_W{1'b0}};
            err_way_o    <= {WAY_W{1'b0}};
        end else if (clear_i) begin
            corr_cnt_o   <= {CNT_WIDTH{1'b0}};
            uncorr_cnt_o <= {CNT_WIDTH{1'b0}};
            err_vld_o    <= 1'b0;
            err_addr_o   <= {IDX_W{1'b0}};
            err_way_o    <= {WAY_W{1'b0}};
        end else begin
            if (rsp_corr_s) begin
                corr_cnt_o <= sat_inc(corr_cnt_o);
            end
            if (rsp_uncorr_s) begin
                uncorr_cnt_o <= sat_inc(uncorr_cnt_o);
                if (!err_vld_o) begin
                    err_vld_o  <= 1'b1;
                    err_addr_o <= idx_r;
                    err_way_o  <= way_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_ecc_scrubber.sv
// Testbench for dcache_ecc_scrubber: scoreboard of expected array accesses,
// a read-response model with per-entry error injection, a table of error
// vectors, and hand-written sequences for reset, full sweep, abort and
// interval/start timing.
module tb_dcache_ecc_scrubber;
    localparam int NW = 256;
    localparam int SA = 8;
    localparam int LW = 256;
    localparam int IW = 16;
    localparam int CW = 16;

    logic          clk_i        = 1'b0;
    logic          rst_ni       = 1'b0;
    logic          enable_i     = 1'b0;
    logic          start_i      = 1'b0;
    logic          clear_i      = 1'b0;
    logic [IW-1:0] interval_i   = '0;
    logic          gnt_i        = 1'b0;
    logic          rvalid_i     = 1'b0;
    logic          corr_err_i   = 1'b0;
    logic          uncorr_err_i = 1'b0;
    logic [LW-1:0] corr_data_i  = '0;
    logic          req_o, we_o, busy_o, sweep_done_o, uncorr_o, err_vld_o;
    logic [7:0]    addr_o, err_addr_o;
    logic [SA-1:0] way_o;
    logic [LW-1:0] wdata_o;
    logic [CW-1:0] corr_cnt_o, uncorr_cnt_o;
    logic [2:0]    err_way_o;

    dcache_ecc_scrubber dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .start_i(start_i),
        .clear_i(clear_i), .interval_i(interval_i), .req_o(req_o), .we_o(we_o),
        .addr_o(addr_o), .way_o(way_o), .wdata_o(wdata_o), .gnt_i(gnt_i),
        .rvalid_i(rvalid_i), .corr_err_i(corr_err_i), .uncorr_err_i(uncorr_err_i),
        .corr_data_i(corr_data_i), .busy_o(busy_o), .sweep_done_o(sweep_done_o),
        .uncorr_o(uncorr_o), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
        .err_vld_o(err_vld_o), .err_addr_o(err_addr_o), .err_way_o(err_way_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we;
        logic [7:0]    addr;
        logic [SA-1:0] way;
        logic [LW-1:0] wdata;
    } acc_t;

    typedef struct {
        int            set;
        int            way;
        logic          corr;
        logic          unc;
        logic          clr;
        logic          sat;
        logic [7:0]    data;
        logic [CW-1:0] e_corr;
        logic [CW-1:0] e_unc;
        logic          e_vld;
        logic [7:0]    e_addr;
        logic [2:0]    e_way;
    } vec_t;

    acc_t exp_q[$];
    int   grant_t[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   unc_pulses = 0;
    int   sweep_cnt = 0;
    int   sweep_t = 0;
    int   last_grant_t = 0;
    int   cur_set = 0;
    int   cur_way = 0;

    logic       inj_on = 1'b0;
    int         inj_set = 0;
    int         inj_way = 0;
    logic       inj_corr = 1'b0;
    logic       inj_unc = 1'b0;
    logic       inj_clr = 1'b0;
    logic [7:0] inj_byte = 8'h00;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [SA-1:0] oh(input int w);
        logic [SA-1:0] r;
        r = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Queue the read of the cursor entry (and its write-back) and advance the cursor model.
    task automatic push_next(input logic wr, input logic [7:0] b);
        acc_t a;
        a.we = 1'b0; a.addr = 8'(cur_set); a.way = oh(cur_way); a.wdata = '0;
        exp_q.push_back(a);
        if (wr) begin
            a.we = 1'b1; a.wdata = {32{b}};
            exp_q.push_back(a);
        end
        cur_way++;
        if (cur_way == SA) begin
            cur_way = 0;
            cur_set = (cur_set + 1) % NW;
        end
    endtask

    // Enable until every queued access has been seen, then disable and settle.
    task automatic drain(input int bound, input string name);
        int n;
        n = 0;
        enable_i = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk_i);
            n++;
        end
        enable_i = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk_i);
    endtask

    // Monitor/scoreboard at negedge and read-response model driven 1 cycle after each read grant.
    initial begin : responder
        acc_t       e;
        logic       pend, pc, pu, pclr, hit;
        logic [7:0] pb;
        pend = 1'b0; pc = 1'b0; pu = 1'b0; pclr = 1'b0; pb = 8'hEE;
        forever begin
            @(negedge clk_i);
            if (uncorr_o) unc_pulses++;
            if (sweep_done_o) begin
                sweep_cnt++;
                sweep_t = cyc;
            end
            if (rst_ni && req_o && gnt_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_access actual we=%0d addr=%0d way=%0h required no access",
                             we_o, addr_o, way_o);
                end else begin
                    e = exp_q.pop_front();
                    if (we_o !== e.we || addr_o !== e.addr || way_o !== e.way ||
                        (e.we && wdata_o !== e.wdata)) begin
                        errors++;
                        $display("FAIL access actual we=%0d addr=%0d way=%0h wdata=%0h required we=%0d addr=%0d way=%0h wdata=%0h",
                                 we_o, addr_o, way_o, wdata_o, e.we, e.addr, e.way, e.wdata);
                    end
                end
                if (!we_o) begin
                    grant_t.push_back(cyc);
                    last_grant_t = cyc;
                    hit  = inj_on && (addr_o == 8'(inj_set)) && (way_o == oh(inj_way));
                    pend = 1'b1;
                    pc   = hit && inj_corr;
                    pu   = hit && inj_unc;
                    pclr = hit && inj_clr;
                    pb   = hit ? inj_byte : 8'hEE;
                end
            end
            @(posedge clk_i);
            #1;
            rvalid_i     = pend;
            corr_err_i   = pend && pc;
            uncorr_err_i = pend && pu;
            clear_i      = pend && pclr;
            corr_data_i  = {32{pb}};
            pend = 1'b0; pc = 1'b0; pu = 1'b0; pclr = 1'b0;
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vt[9];
        int   n, gap, exp_pulses;

        vt[0] = '{3,  5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 16'd1,      16'd0, 1'b0, 8'd0,  3'd0};
        vt[1] = '{7,  2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd1,      16'd1, 1'b1, 8'd7,  3'd2};
        vt[2] = '{9,  1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd1,      16'd2, 1'b1, 8'd7,  3'd2};
        vt[3] = '{10, 6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 16'd1,      16'd3, 1'b1, 8'd7,  3'd2};
        vt[4] = '{11, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 16'd2,      16'd3, 1'b1, 8'd7,  3'd2};
        vt[5] = '{12, 3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 16'hFFFF,   16'd3, 1'b1, 8'd7,  3'd2};
        vt[6] = '{13, 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 16'd0,      16'd0, 1'b0, 8'd0,  3'd0};
        vt[7] = '{14, 7, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0,      16'd0, 1'b0, 8'd0,  3'd0};
        vt[8] = '{20, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0,      16'd1, 1'b1, 8'd20, 3'd2};

        // Reset, with enable high to show reset dominates.
        enable_i = 1'b1;
        gnt_i    = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_req", req_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_way", way_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sweep", sweep_done_o, 0);
        chk("rst_uncorr", uncorr_o, 0);
        chk("rst_corr_cnt", corr_cnt_o, 0);
        chk("rst_uncorr_cnt", uncorr_cnt_o, 0);
        chk("rst_err_vld", err_vld_o, 0);
        chk("rst_err_addr", err_addr_o, 0);
        chk("rst_err_way", err_way_o, 0);
        enable_i = 1'b0;
        rst_ni   = 1'b1;
        repeat (2) @(negedge clk_i);

        // Full sweep, interval 0, no errors.
        for (int i = 0; i < NW * SA; i++) push_next(1'b0, 8'h00);
        drain(30000, "sweep");
        chk("sweep_count", sweep_cnt, 1);
        chk("sweep_after_last_read", sweep_t - last_grant_t, 2);
        chk("sweep_busy", busy_o, 0);
        chk("sweep_corr_cnt", corr_cnt_o, 0);
        chk("sweep_uncorr_cnt", uncorr_cnt_o, 0);

        // Abort a pending read by dropping enable; re-enable reads the same entry.
        gnt_i    = 1'b0;
        enable_i = 1'b1;
        n = 0;
        while (!req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("abort_req_up", req_o, 1);
        chk("abort_we", we_o, 0);
        repeat (3) @(negedge clk_i);
        chk("abort_req_held", req_o, 1);
        chk("abort_addr", addr_o, 8'(cur_set));
        chk("abort_way", way_o, oh(cur_way));
        enable_i = 1'b0;
        @(negedge clk_i);
        chk("abort_req_drop", req_o, 0);
        chk("abort_idle", busy_o, 0);
        @(negedge clk_i);
        gnt_i = 1'b1;
        push_next(1'b0, 8'h00);
        drain(50, "abort_resume");

        // Interval of 10 idle cycles, then start_i cuts a wait short.
        interval_i = 16'd10;
        grant_t.delete();
        repeat (3) push_next(1'b0, 8'h00);
        enable_i = 1'b1;
        n = 0;
        while (grant_t.size() < 2 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        gap = (grant_t.size() >= 2) ? grant_t[1] - grant_t[0] : -1;
        chk("interval_gap", gap, 14);
        repeat (5) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_req", req_o, 1);
        drain(100, "interval");
        interval_i = 16'd0;

        // Error-injection vectors.
        exp_pulses = 0;
        for (int v = 0; v < 9; v++) begin
            if (vt[v].sat) begin
                force dut.corr_cnt_o = 16'hFFFF;
                @(negedge clk_i);
                release dut.corr_cnt_o;
                @(negedge clk_i);
            end
            while (cur_set != vt[v].set || cur_way != vt[v].way) push_next(1'b0, 8'h00);
            inj_set  = vt[v].set;
            inj_way  = vt[v].way;
            inj_corr = vt[v].corr;
            inj_unc  = vt[v].unc;
            inj_clr  = vt[v].clr;
            inj_byte = vt[v].data;
            inj_on   = 1'b1;
            push_next(vt[v].corr && !vt[v].unc, vt[v].data);
            if (vt[v].unc) exp_pulses++;
            drain(2000, $sformatf("vec%0d", v));
            inj_on = 1'b0;
            chk($sformatf("vec%0d_corr_cnt", v), corr_cnt_o, vt[v].e_corr);
            chk($sformatf("vec%0d_uncorr_cnt", v), uncorr_cnt_o, vt[v].e_unc);
            chk($sformatf("vec%0d_err_vld", v), err_vld_o, vt[v].e_vld);
            chk($sformatf("vec%0d_err_addr", v), err_addr_o, vt[v].e_addr);
            chk($sformatf("vec%0d_err_way", v), err_way_o, vt[v].e_way);
            chk($sformatf("vec%0d_uncorr_pulses", v), unc_pulses, exp_pulses);
            chk($sformatf("vec%0d_busy", v), busy_o, 0);
        end
        chk("final_sweep_count", sweep_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
